id_ex_stage: RTL and testbench

//  Decode stage and ID/EX pipeline register of the 8-bit RISC-V pipeline. It drives the

---
 rtl/id_ex_stage.sv | 233 +++++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode stage plus ID/EX pipeline register of the 8-bit RISC-V core.
// It drives the register-file read addresses, aligns the decoded fields with the file's
// one-cycle registered read data, and raises a one-cycle load-use stall.
// Optional feature macro: WB_BYPASS_EN. When it is defined, a writeback that lands on the
// same edge the file is read is captured locally. The file returns the old value in that
// case, so without the capture the operand would be stale.
module id_ex_stage #(
    parameter int unsigned XLEN     = 8,            // immediate truncation assumes XLEN <= 32
    parameter logic [6:0]  LOAD_OPC = 7'b0000011
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [31:0]     in_instr,
    input  logic [7:0]      in_pc,
    input  logic            ex_stall,
    input  logic            flush,
    output logic [4:0]      rf_read_reg1,
    output logic [4:0]      rf_read_reg2,
    input  logic [XLEN-1:0] rf_read_data1,
    input  logic [XLEN-1:0] rf_read_data2,
    input  logic            wb_reg_write,
    input  logic [4:0]      wb_write_reg,
    input  logic [XLEN-1:0] wb_write_data,
    output logic            hazard_stall,
    output logic            out_valid,
    output logic [XLEN-1:0] out_rs1_data,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic            out_funct7b5,
    output logic [7:0]      out_pc
);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic            valid_q,    valid_d;
    logic [4:0]      rs1_q,      rs1_d;
    logic [4:0]      rs2_q,      rs2_d;
    logic [4:0]      rd_q,       rd_d;
    logic [6:0]      opcode_q,   opcode_d;
    logic [2:0]      funct3_q,   funct3_d;
    logic            funct7b5_q, funct7b5_d;
    logic [XLEN-1:0] imm_q,      imm_d;
    logic [7:0]      pc_q,       pc_d;

    logic [31:0]     imm_full_s;
    logic            hazard_s;
    logic            accept_s;
    logic            load_s;

    assign accept_s = in_valid & ~ex_stall & ~hazard_s;
    assign load_s   = accept_s & ~flush;

    // Load-use detection: a load in this stage whose rd is a source of the incoming instruction
    always_comb begin
        hazard_s = 1'b0;
        if (valid_q && (opcode_q == LOAD_OPC) && (rd_q != 5'd0) && in_valid &&
            ((in_instr[19:15] == rd_q) || (in_instr[24:20] == rd_q))) begin
            hazard_s = 1'b1;
        end else begin
            hazard_s = 1'b0;
        end
    end

    // Read address: re-read the held sources while EX is stalled so the operands stay current
    always_comb begin
        rf_read_reg1 = in_instr[19:15];
        rf_read_reg2 = in_instr[24:20];
        if (ex_stall) begin
            rf_read_reg1 = rs1_q;
            rf_read_reg2 = rs2_q;
        end else begin
            rf_read_reg1 = in_instr[19:15];
            rf_read_reg2 = in_instr[24:20];
        end
    end

    // Immediate decode: full sign-extended RISC-V immediate, later truncated to XLEN
    always_comb begin
        imm_full_s = 32'd0;
        case (in_instr[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR:
                imm_full_s = {{20{in_instr[31]}}, in_instr[31:20]};
            OPC_STORE:
                imm_full_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            OPC_BRANCH:
                imm_full_s = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                              in_instr[30:25], in_instr[11:8], 1'b0};
            default:
                imm_full_s = 32'd0;
        endcase
    end

    // Next-state of the pipeline register: flush beats stall, stall beats accept, else bubble
    always_comb begin
        valid_d    = valid_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        opcode_d   = opcode_q;
        funct3_d   = funct3_q;
        funct7b5_d = funct7b5_q;
        imm_d      = imm_q;
        pc_d       = pc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (ex_stall) begin
            valid_d = valid_q;
        end else if (accept_s) begin
            valid_d    = 1'b1;
            rs1_d      = in_instr[19:15];
            rs2_d      = in_instr[24:20];
            rd_d       = in_instr[11:7];
            opcode_d   = in_instr[6:0];
            funct3_d   = in_instr[14:12];
            funct7b5_d = in_instr[30];
            imm_d      = imm_full_s[XLEN-1:0];
            pc_d       = in_pc;
        end else begin
            valid_d = 1'b0;
        end
    end

    // Pipeline register with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q    <= 1'b0;
            rs1_q      <= 5'd0;
            rs2_q      <= 5'd0;
            rd_q       <= 5'd0;
            opcode_q   <= 7'd0;
            funct3_q   <= 3'd0;
            funct7b5_q <= 1'b0;
            imm_q      <= '0;
            pc_q       <= 8'd0;
        end else begin
            valid_q    <= valid_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            opcode_q   <= opcode_d;
            funct3_q   <= funct3_d;
            funct7b5_q <= funct7b5_d;
            imm_q      <= imm_d;
            pc_q       <= pc_d;
        end
    end

`ifdef WB_BYPASS_EN
    logic            byp1_q,     byp1_d;
    logic            byp2_q,     byp2_d;
    logic [XLEN-1:0] byp1_val_q, byp1_val_d;
    logic [XLEN-1:0] byp2_val_q, byp2_val_d;

    function automatic logic wb_hit(input logic we, input logic [4:0] wreg, input logic [4:0] rs);
        return we && (wreg == rs) && (rs != 5'd0);
    endfunction

    // Capture a writeback to the register the file is reading on this same edge
    always_comb begin
        byp1_d     = byp1_q;
        byp2_d     = byp2_q;
        byp1_val_d = byp1_val_q;
        byp2_val_d = byp2_val_q;
        if (load_s || ex_stall) begin
            byp1_d     = wb_hit(wb_reg_write, wb_write_reg, rf_read_reg1);
            byp2_d     = wb_hit(wb_reg_write, wb_write_reg, rf_read_reg2);
            byp1_val_d = byp1_d ? wb_write_data : byp1_val_q;
            byp2_val_d = byp2_d ? wb_write_data : byp2_val_q;
        end else begin
            byp1_d = byp1_q;
            byp2_d = byp2_q;
        end
    end

    // Bypass flags and captured values
    always_ff @(posedge clock) begin
        if (reset) begin
            byp1_q     <= 1'b0;
            byp2_q     <= 1'b0;
            byp1_val_q <= '0;
            byp2_val_q <= '0;
        end else begin
            byp1_q     <= byp1_d;
            byp2_q     <= byp2_d;
            byp1_val_q <= byp1_val_d;
            byp2_val_q <= byp2_val_d;
        end
    end

    // Operand select: x0 forced to zero, captured writeback over stale file data
    always_comb begin
        out_rs1_data = rf_read_data1;
        out_rs2_data = rf_read_data2;
        if (rs1_q == 5'd0)  out_rs1_data = '0;
        else if (byp1_q)    out_rs1_data = byp1_val_q;
        else                out_rs1_data = rf_read_data1;
        if (rs2_q == 5'd0)  out_rs2_data = '0;
        else if (byp2_q)    out_rs2_data = byp2_val_q;
        else                out_rs2_data = rf_read_data2;
    end
`else
    logic unused_wb_s;
    assign unused_wb_s = ^{wb_reg_write, wb_write_reg, wb_write_data};

    // Operand select: x0 forced to zero because the file does not hard-wire it
    always_comb begin
        out_rs1_data = rf_read_data1;
        out_rs2_data = rf_read_data2;
        if (rs1_q == 5'd0) out_rs1_data = '0;
        else               out_rs1_data = rf_read_data1;
        if (rs2_q == 5'd0) out_rs2_data = '0;
        else               out_rs2_data = rf_read_data2;
    end
`endif

    assign hazard_stall = hazard_s;
    assign out_valid    = valid_q;
    assign out_imm      = imm_q;
    assign out_rd       = rd_q;
    assign out_opcode   = opcode_q;
    assign out_funct3   = funct3_q;
    assign out_funct7b5 = funct7b5_q;
    assign out_pc       = pc_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed table and sequences, then random traffic against a model.
module tb_id_ex_stage;
    localparam int XLEN = 8;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset, in_valid, ex_stall, flush, wb_reg_write;
    logic [31:0] in_instr;
    logic [7:0] in_pc;
    logic [4:0] rf_read_reg1, rf_read_reg2, wb_write_reg;
    logic [XLEN-1:0] rf_read_data1, rf_read_data2, wb_write_data;
    logic hazard_stall, out_valid, out_funct7b5;
    logic [XLEN-1:0] out_rs1_data, out_rs2_data, out_imm;
    logic [4:0] out_rd;
    logic [6:0] out_opcode;
    logic [2:0] out_funct3;
    logic [7:0] out_pc;

    id_ex_stage #(.XLEN(XLEN), .LOAD_OPC(7'b0000011)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
        .ex_stall(ex_stall), .flush(flush),
        .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
        .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
        .hazard_stall(hazard_stall), .out_valid(out_valid),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
        .out_rd(out_rd), .out_opcode(out_opcode), .out_funct3(out_funct3),
        .out_funct7b5(out_funct7b5), .out_pc(out_pc)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // register file of the environment, and its contents before the latest edge's write
    logic [7:0] rf [32];
    logic [7:0] rf_prev [32];

    // reference model of the stage: what was last accepted and whether it is live
    bit         m_live = 1'b0;
    bit         m_valid;
    logic [4:0] m_rs1, m_rs2, m_rd;
    logic [6:0] m_opc;
    logic [2:0] m_f3;
    logic       m_f7;
    logic [7:0] m_imm, m_pc, m_op1, m_op2;

    typedef struct {
        logic [31:0] instr;
        logic [7:0]  imm;
        logic [4:0]  rd;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7b5;
    } dec_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // RISC-V immediate by instruction format, as a signed integer reduced modulo 2**8
    function automatic logic [7:0] ref_imm(input logic [31:0] ins);
        int v;
        case (ins[6:0])
            7'h13, 7'h03, 7'h67: v = int'($signed(ins[31:20]));
            7'h23:               v = int'($signed({ins[31:25], ins[11:7]}));
            7'h63:               v = int'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            default:             v = 0;
        endcase
        return v[7:0];
    endfunction

    // operand seen one cycle after the file is read at register r
    function automatic logic [7:0] ref_val(input logic [4:0] r);
        if (r == 5'd0) return 8'h00;
        return BYP ? rf[r] : rf_prev[r];
    endfunction

    function automatic bit ref_hazard();
        return m_valid && (m_opc == 7'h03) && (m_rd != 5'd0) && in_valid &&
               ((in_instr[19:15] == m_rd) || (in_instr[24:20] == m_rd));
    endfunction

    task automatic model_check();
        logic [4:0] ea1, ea2;
        if (!m_live) return;
        ea1 = ex_stall ? m_rs1 : in_instr[19:15];
        ea2 = ex_stall ? m_rs2 : in_instr[24:20];
        chk("hazard_stall", hazard_stall, ref_hazard());
        chk("rf_read_reg1", rf_read_reg1, ea1);
        chk("rf_read_reg2", rf_read_reg2, ea2);
        chk("out_valid", out_valid, m_valid);
        if (m_valid) begin
            chk("out_rd", out_rd, m_rd);
            chk("out_opcode", out_opcode, m_opc);
            chk("out_funct3", out_funct3, m_f3);
            chk("out_funct7b5", out_funct7b5, m_f7);
            chk("out_imm", out_imm, m_imm);
            chk("out_pc", out_pc, m_pc);
        end
        if (m_valid || m_rs1 == 5'd0) chk("out_rs1_data", out_rs1_data, m_op1);
        if (m_valid || m_rs2 == 5'd0) chk("out_rs2_data", out_rs2_data, m_op2);
    endtask

    // one clock: check, advance, let the file answer, update the model; returns at negedge
    task automatic step();
        logic [4:0] a1, a2;
        bit hz;
        model_check();
        a1 = rf_read_reg1;
        a2 = rf_read_reg2;
        hz = ref_hazard();
        @(posedge clock);
        #1;
        rf_prev = rf;
        rf_read_data1 = rf[a1];
        rf_read_data2 = rf[a2];
        if (wb_reg_write) rf[wb_write_reg] = wb_write_data;
        if (reset) begin
            m_live = 1'b1; m_valid = 1'b0;
            m_rs1 = 5'd0; m_rs2 = 5'd0; m_rd = 5'd0; m_opc = 7'd0; m_f3 = 3'd0; m_f7 = 1'b0;
            m_imm = 8'd0; m_pc = 8'd0; m_op1 = 8'd0; m_op2 = 8'd0;
        end else if (flush) begin
            m_valid = 1'b0;
        end else if (ex_stall) begin
            m_op1 = ref_val(m_rs1);
            m_op2 = ref_val(m_rs2);
        end else if (in_valid && !hz) begin
            m_valid = 1'b1;
            m_rs1 = in_instr[19:15]; m_rs2 = in_instr[24:20]; m_rd = in_instr[11:7];
            m_opc = in_instr[6:0]; m_f3 = in_instr[14:12]; m_f7 = in_instr[30];
            m_imm = ref_imm(in_instr); m_pc = in_pc;
            m_op1 = ref_val(m_rs1); m_op2 = ref_val(m_rs2);
        end else begin
            m_valid = 1'b0;
        end
        @(negedge clock);
    endtask

    initial begin
        dec_vec_t tbl[6];
        logic [6:0] opcs[6];
        logic [31:0] ins;

        // addi, sw, beq, sub, lui, lw (lw last: the load-use sequence relies on it)
        tbl[0] = '{32'h01200293, 8'h12, 5'd5,  7'h13, 3'd0, 1'b0};
        tbl[1] = '{32'h1A74A5A3, 8'hAB, 5'd11, 7'h23, 3'd2, 1'b0};
        tbl[2] = '{32'h0A208B63, 8'hB6, 5'd22, 7'h63, 3'd0, 1'b0};
        tbl[3] = '{32'h40118233, 8'h00, 5'd4,  7'h33, 3'd0, 1'b1};
        tbl[4] = '{32'hABCDE537, 8'h00, 5'd10, 7'h37, 3'd6, 1'b0};
        tbl[5] = '{32'hFFC12183, 8'hFC, 5'd3,  7'h03, 3'd2, 1'b1};
        opcs = '{7'h13, 7'h03, 7'h23, 7'h63, 7'h33, 7'h37};

        for (int i = 0; i < 32; i++) rf[i] = 8'h10 + 8'(i);
        rf[0] = 8'h7F;
        rf_prev = rf;
        rf_read_data1 = 8'h00; rf_read_data2 = 8'h00;
        reset = 1'b1; in_valid = 1'b0; in_instr = 32'd0; in_pc = 8'd0;
        ex_stall = 1'b0; flush = 1'b0;
        wb_reg_write = 1'b0; wb_write_reg = 5'd0; wb_write_data = 8'd0;

        // reset for two cycles, then everything reads zero
        @(negedge clock);
        step(); step();
        reset = 1'b0;
        #1;
        chk("rst out_valid", out_valid, 1'b0);
        chk("rst hazard", hazard_stall, 1'b0);
        chk("rst rs1_data", out_rs1_data, 8'h00);
        chk("rst rs2_data", out_rs2_data, 8'h00);
        chk("rst imm", out_imm, 8'h00);
        chk("rst rd", out_rd, 5'd0);
        chk("rst opcode", out_opcode, 7'd0);
        chk("rst pc", out_pc, 8'd0);
        in_instr = 32'h00208433; ex_stall = 1'b1;
        #1;
        chk("rst held addr1", rf_read_reg1, 5'd0);
        chk("rst held addr2", rf_read_reg2, 5'd0);
        step();
        ex_stall = 1'b0;

        // addi x5,x0,0x12 with x0 holding 0x7F in the file
        in_instr = 32'h01200293; in_valid = 1'b1; in_pc = 8'h40;
        #1; step();
        in_valid = 1'b0;
        #1;
        chk("addi valid", out_valid, 1'b1);
        chk("addi rs1 x0", out_rs1_data, 8'h00);
        chk("addi imm", out_imm, 8'h12);
        chk("addi rd", out_rd, 5'd5);
        chk("addi pc", out_pc, 8'h40);

        // decode table
        for (int i = 0; i < 6; i++) begin
            in_instr = tbl[i].instr; in_valid = 1'b1; in_pc = 8'h50 + 8'(i);
            #1; step();
            in_valid = 1'b0;
            #1;
            chk("tbl valid", out_valid, 1'b1);
            chk("tbl imm", out_imm, tbl[i].imm);
            chk("tbl rd", out_rd, tbl[i].rd);
            chk("tbl opcode", out_opcode, tbl[i].opc);
            chk("tbl funct3", out_funct3, tbl[i].f3);
            chk("tbl funct7b5", out_funct7b5, tbl[i].f7b5);
        end

        // load-use: lw x3 is in the stage, add x4,x3,x1 arrives
        in_instr = 32'h00118233; in_valid = 1'b1; in_pc = 8'h60;
        #1;
        chk("lu hazard set", hazard_stall, 1'b1);
        step(); #1;
        chk("lu bubble", out_valid, 1'b0);
        chk("lu hazard clear", hazard_stall, 1'b0);
        step();
        in_valid = 1'b0;
        #1;
        chk("lu issue valid", out_valid, 1'b1);
        chk("lu issue rd", out_rd, 5'd4);

        // add x8,x1,x2 accepted while WB writes x2=0x55, then EX stalls 3 cycles
        in_instr = 32'h00208433; in_valid = 1'b1; in_pc = 8'h64;
        wb_reg_write = 1'b1; wb_write_reg = 5'd2; wb_write_data = 8'h55;
        #1; step();
        in_valid = 1'b0; wb_reg_write = 1'b0; ex_stall = 1'b1;
        #1;
        chk("stall c1 valid", out_valid, 1'b1);
        step(); #1;
        chk("stall c2 rs2", out_rs2_data, 8'h55);
        chk("stall c2 rd", out_rd, 5'd8);
        step(); #1;
        chk("stall c3 rs2", out_rs2_data, 8'h55);
        chk("stall c3 valid", out_valid, 1'b1);
        step();
        ex_stall = 1'b0;

        // flush together with accept, then the next instruction issues
        in_instr = 32'h00100313; in_valid = 1'b1; flush = 1'b1;
        #1; step();
        flush = 1'b0; in_instr = 32'h00500393;
        #1;
        chk("flush valid", out_valid, 1'b0);
        step();
        in_valid = 1'b0;
        #1;
        chk("post flush valid", out_valid, 1'b1);
        chk("post flush rd", out_rd, 5'd7);

        // same-edge writeback of x6 while addi x9,x6,1 is accepted
        in_instr = 32'h00130493; in_valid = 1'b1;
        wb_reg_write = 1'b1; wb_write_reg = 5'd6; wb_write_data = 8'hA5;
        #1; step();
        in_valid = 1'b0; wb_reg_write = 1'b0;
        #1;
        chk("bypass rs1", out_rs1_data, BYP ? 8'hA5 : 8'h16);

        // random traffic against the model
        for (int n = 0; n < 800; n++) begin
            ins = $urandom;
            ins[6:0]   = opcs[$urandom_range(0, 5)];
            ins[11:7]  = 5'($urandom_range(0, 7));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            in_instr      = ins;
            in_pc         = 8'($urandom);
            in_valid      = ($urandom_range(0, 3) != 0);
            ex_stall      = ($urandom_range(0, 3) == 0);
            flush         = ($urandom_range(0, 9) == 0);
            reset         = ($urandom_range(0, 59) == 0);
            wb_reg_write  = ($urandom_range(0, 1) == 1);
            wb_write_reg  = 5'($urandom_range(0, 7));
            wb_write_data = 8'($urandom);
            #1; step();
        end

        reset = 1'b0; in_valid = 1'b0; ex_stall = 1'b0; flush = 1'b0; wb_reg_write = 1'b0;
        #1; step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
